xpm_fifo_sync_fwft: RTL and testbench

// Single-clock FIFO with first-word-fall-through (FWFT) read mode. It is the deep-buffer backend behind the generic

---
 rtl/xpm_fifo_sync_fwft.sv | 113 +++++++++++
 tb/tb_xpm_fifo_sync_fwft.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/xpm_fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO: RAM array, wrapping pointers, occupancy counter driving registered flags.
// Head word visible on dout the cycle after it is written; full/empty/threshold flags derive from next-cycle occupancy.
module xpm_fifo_sync_fwft #(
  parameter int FIFO_WRITE_DEPTH  = 2048,
  parameter int WRITE_DATA_WIDTH  = 32,
  parameter int READ_DATA_WIDTH   = 32,
  parameter int PROG_FULL_THRESH  = 10,
  parameter int PROG_EMPTY_THRESH = 10,
  parameter int FULL_RESET_VALUE  = 0,
  parameter logic [255:0] DOUT_RESET_VALUE = "0"
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WRITE_DATA_WIDTH-1:0]         din,
  input  logic                                wr_en,
  output logic                                full,
  output logic                                overflow,
  output logic                                wr_ack,
  output logic                                prog_full,
  output logic                                almost_full,
  output logic [READ_DATA_WIDTH-1:0]          dout,
  input  logic                                rd_en,
  output logic                                empty,
  output logic                                data_valid,
  output logic                                underflow,
  output logic                                prog_empty,
  output logic                                almost_empty,
  output logic [$clog2(FIFO_WRITE_DEPTH):0]   data_count
);

  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  localparam int CW = AW + 1;

  if (READ_DATA_WIDTH != WRITE_DATA_WIDTH) begin : g_width_check
    $error("xpm_fifo_sync_fwft: READ_DATA_WIDTH must equal WRITE_DATA_WIDTH");
  end

  // Hex string parameter is right-justified in 256 bits; leading NUL padding is skipped.
  function automatic logic [WRITE_DATA_WIDTH-1:0] hex_val(input logic [255:0] s);
    logic [WRITE_DATA_WIDTH-1:0] v;
    logic [7:0]                  c;
    logic [3:0]                  nib;
    v = '0;
    for (int i = 31; i >= 0; i--) begin
      c   = s[8*i +: 8];
      nib = 4'd0;
      if (c >= "0" && c <= "9")      nib = 4'(c - 8'h30);
      else if (c >= "a" && c <= "f") nib = 4'(c - 8'h57);
      else if (c >= "A" && c <= "F") nib = 4'(c - 8'h37);
      if (c != 8'h00) v = (v << 4) | WRITE_DATA_WIDTH'(nib);
    end
    return v;
  endfunction

  localparam logic [WRITE_DATA_WIDTH-1:0] DOUT_RST = hex_val(DOUT_RESET_VALUE);

  logic [WRITE_DATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count, count_next;
  logic [WRITE_DATA_WIDTH-1:0] dout_hold;
  logic                        full_q, empty_q;
  logic                        wr_acc, rd_acc;

  assign wr_acc     = wr_en & ~full_q;
  assign rd_acc     = rd_en & ~empty_q;
  assign count_next = count + CW'(wr_acc) - CW'(rd_acc);

  always_ff @(posedge clock) begin
    if (!reset && wr_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full    <= 1'b0;
      almost_full  <= 1'b0;
      prog_empty   <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      wr_ack       <= 1'b0;
      dout_hold    <= DOUT_RST;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        dout_hold <= mem[rd_ptr];
      end
      count        <= count_next;
      full_q       <= (count_next == CW'(FIFO_WRITE_DEPTH));
      empty_q      <= (count_next == '0);
      prog_full    <= (count_next >= CW'(PROG_FULL_THRESH));
      almost_full  <= (count_next >= CW'(FIFO_WRITE_DEPTH - 1));
      prog_empty   <= (count_next <= CW'(PROG_EMPTY_THRESH));
      almost_empty <= (count_next <= CW'(1));
      overflow     <= wr_en & ~wr_acc;
      underflow    <= rd_en & ~rd_acc;
      wr_ack       <= wr_acc;
    end
  end

  // While empty, dout keeps the last popped word (or the reset value).
  assign dout       = empty_q ? dout_hold : mem[rd_ptr];
  assign full       = reset ? (FULL_RESET_VALUE != 0) : full_q;
  assign empty      = empty_q;
  assign data_valid = ~empty_q;
  assign data_count = count;

endmodule

// File: tb/tb_xpm_fifo_sync_fwft.sv
// Bench for xpm_fifo_sync_fwft at DEPTH=64: occupancy model plus data scoreboard, directed phases and a random stream.
module tb_xpm_fifo_sync_fwft;

  localparam int DEPTH = 64;
  localparam int W     = 16;
  localparam int PF    = 56;
  localparam int PE    = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din   = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic         full, overflow, wr_ack, prog_full, almost_full;
  logic [W-1:0] dout;
  logic         empty, data_valid, underflow, prog_empty, almost_empty;
  logic [6:0]   data_count;

  int checks = 0;
  int errors = 0;
  int npop   = 0;

  logic [W-1:0] sbq[$];
  int           mcnt  = 0;
  logic         e_ovf = 1'b0, e_udf = 1'b0, e_ack = 1'b0;

  xpm_fifo_sync_fwft #(
    .FIFO_WRITE_DEPTH(DEPTH), .WRITE_DATA_WIDTH(W), .READ_DATA_WIDTH(W),
    .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE), .FULL_RESET_VALUE(0),
    .DOUT_RESET_VALUE("0")
  ) dut (
    .clock(clock), .reset(reset), .din(din), .wr_en(wr_en), .full(full),
    .overflow(overflow), .wr_ack(wr_ack), .prog_full(prog_full),
    .almost_full(almost_full), .dout(dout), .rd_en(rd_en), .empty(empty),
    .data_valid(data_valid), .underflow(underflow), .prog_empty(prog_empty),
    .almost_empty(almost_empty), .data_count(data_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference occupancy; accepted writes are queued as expected read data.
  always @(posedge clock) begin
    if (reset) begin
      mcnt = 0;
      sbq.delete();
      e_ovf = 1'b0; e_udf = 1'b0; e_ack = 1'b0;
    end else begin
      automatic bit wa = wr_en && (mcnt < DEPTH);
      automatic bit ra = rd_en && (mcnt > 0);
      e_ovf = wr_en && !wa;
      e_udf = rd_en && !ra;
      e_ack = wa;
      if (wa) sbq.push_back(din);
      mcnt = mcnt + int'(wa) - int'(ra);
    end
  end

  // Monitor: data handshake about to complete, plus every flag against the model.
  always @(negedge clock) begin
    if (!reset) begin
      if (rd_en && !empty) begin
        if (sbq.size() == 0) begin
          chk("dout_unexpected", 64'(dout), 64'hx);
        end else begin
          chk("dout", 64'(dout), 64'(sbq.pop_front()));
          npop++;
        end
      end
      chk("empty",        64'(empty),        64'(mcnt == 0));
      chk("data_valid",   64'(data_valid),   64'(mcnt != 0));
      chk("full",         64'(full),         64'(mcnt == DEPTH));
      chk("data_count",   64'(data_count),   64'(mcnt));
      chk("prog_full",    64'(prog_full),    64'(mcnt >= PF));
      chk("prog_empty",   64'(prog_empty),   64'(mcnt <= PE));
      chk("almost_full",  64'(almost_full),  64'(mcnt >= DEPTH - 1));
      chk("almost_empty", 64'(almost_empty), 64'(mcnt <= 1));
      chk("overflow",     64'(overflow),     64'(e_ovf));
      chk("underflow",    64'(underflow),    64'(e_udf));
      chk("wr_ack",       64'(wr_ack),       64'(e_ack));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, base, guard;
    logic [W-1:0] nxt;

    // Reset state
    tick(); tick();
    chk("rst_full", 64'(full), 64'd0);
    tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(data_count), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_prog_empty", 64'(prog_empty), 64'd1);
    chk("rst_almost_empty", 64'(almost_empty), 64'd1);
    reset = 1'b0;
    tick();

    // FWFT: 1,2,3
    wr_en = 1'b1; din = 16'd1; tick();
    chk("fwft_empty", 64'(empty), 64'd0);
    chk("fwft_dout", 64'(dout), 64'd1);
    din = 16'd2; tick();
    din = 16'd3; tick();
    wr_en = 1'b0;
    chk("fwft_head_no_rd", 64'(dout), 64'd1);
    rd_en = 1'b1; tick(); tick(); tick();
    rd_en = 1'b0;
    chk("fwft_drained", 64'(empty), 64'd1);
    chk("fwft_dout_hold", 64'(dout), 64'd3);

    // Fill to prog_full threshold, then to full, then overflow
    wr_en = 1'b1;
    for (int i = 0; i < 55; i++) begin din = 16'(100 + i); tick(); end
    chk("pf_below", 64'(prog_full), 64'd0);
    chk("pf_count55", 64'(data_count), 64'd55);
    din = 16'd155; tick();
    chk("pf_at", 64'(prog_full), 64'd1);
    for (int i = 0; i < 8; i++) begin din = 16'(156 + i); tick(); end
    chk("full_set", 64'(full), 64'd1);
    chk("full_count", 64'(data_count), 64'd64);
    din = 16'd777; tick();
    chk("ovf_pulse", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(data_count), 64'd64);

    // Full with both enables: read wins
    rd_en = 1'b1; din = 16'd999; tick();
    wr_en = 1'b0;
    chk("fullrw_count", 64'(data_count), 64'd63);
    chk("fullrw_full", 64'(full), 64'd0);
    chk("fullrw_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 63; i++) tick();
    rd_en = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);

    // Underflow, then empty with both enables: write wins
    rd_en = 1'b1; tick();
    chk("udf_pulse", 64'(underflow), 64'd1);
    chk("udf_empty", 64'(empty), 64'd1);
    wr_en = 1'b1; din = 16'h0055; tick();
    wr_en = 1'b0;
    chk("emptyrw_count", 64'(data_count), 64'd1);
    chk("emptyrw_udf", 64'(underflow), 64'd1);
    chk("emptyrw_ack", 64'(wr_ack), 64'd1);
    tick();
    rd_en = 1'b0;
    chk("emptyrw_drained", 64'(empty), 64'd1);

    // Random stream across pointer wraps
    base = npop; nwr = 0; nxt = 16'h1000; guard = 0;
    while (nwr < 3 * DEPTH && guard < 5000) begin
      wr_en = ($urandom_range(0, 3) != 0);
      rd_en = ($urandom_range(0, 2) != 0);
      din   = nxt;
      if (wr_en && !full) begin nwr++; nxt++; end
      tick();
      guard++;
    end
    wr_en = 1'b0; rd_en = 1'b1; guard = 0;
    while (!empty && guard < 200) begin tick(); guard++; end
    rd_en = 1'b0;
    chk("stream_done", 64'(nwr), 64'(3 * DEPTH));
    chk("stream_pops", 64'(npop - base), 64'(3 * DEPTH));
    chk("stream_empty", 64'(empty), 64'd1);

    // Reset with contents stored
    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin din = 16'(16'h2000 + i); tick(); end
    wr_en = 1'b0;
    chk("pre_rst_count", 64'(data_count), 64'd20);
    reset = 1'b1; tick();
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_count", 64'(data_count), 64'd0);
    chk("mid_rst_prog_empty", 64'(prog_empty), 64'd1);
    reset = 1'b0;
    wr_en = 1'b1; din = 16'hABCD; tick();
    wr_en = 1'b0;
    chk("post_rst_dout", 64'(dout), 64'hABCD);
    chk("post_rst_count", 64'(data_count), 64'd1);
    rd_en = 1'b1; tick();
    rd_en = 1'b0;
    chk("post_rst_empty", 64'(empty), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
